// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit core: word width, reset PC and fetch FSM states.
package risc_pkg;

  localparam int unsigned WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {inst, pc} FIFO between instruction memory and decode; flush empties it.
module fetch_queue
  import risc_pkg::*;
#(
  parameter int unsigned W = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] push_inst_i,
  input  logic [W-1:0] push_pc_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_inst_o,
  output logic [W-1:0] head_pc_o
);

  logic [W-1:0] inst_q [2];
  logic [W-1:0] pc_q   [2];
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    count_d = count_q + 2'(do_push) - 2'(do_pop);
    if (flush_i) count_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (do_push) begin
          inst_q[wr_ptr_q] <= push_inst_i;
          pc_q[wr_ptr_q]   <= push_pc_i;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign count_o     = count_q;
  assign head_inst_o = inst_q[rd_ptr_q];
  assign head_pc_o   = pc_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, req/ack memory handshake with redirect/drop FSM,
// feeding a 2-entry queue toward decode.
module fetch_unit
  import risc_pkg::*;
#(
  parameter int unsigned      size     = WORD_W,
  parameter logic [size-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [size-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [size-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [size-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [size-1:0] inst,
  output logic [size-1:0] inst_pc
);

  fetch_state_e    state_q, state_d;
  logic [size-1:0] fetch_pc_q, fetch_pc_d;
  logic [size-1:0] addr_q, addr_d;
  logic [1:0]      count, count_post;
  logic            push, pop;

  assign pop  = inst_valid && inst_ready;
  assign push = (state_q == WAIT) && imem_ack && !redirect;

  always_comb begin
    count_post = count + 2'(push) - 2'(pop);
    if (redirect) count_post = 2'd0;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (push)     fetch_pc_d = fetch_pc_q + size'(1);
    if (redirect) fetch_pc_d = redirect_pc;
    unique case (state_q)
      IDLE: if (count_post != 2'd2) state_d = WAIT;
      WAIT: begin
        if (imem_ack)      state_d = (count_post == 2'd2) ? IDLE : WAIT;
        else if (redirect) state_d = DROP;
      end
      DROP: if (imem_ack) state_d = WAIT;
      default: state_d = IDLE;
    endcase
    // The abandoned request keeps its address on the bus until memory acks it.
    addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fetch_queue #(.W(size)) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (redirect),
    .push_inst_i (imem_rdata),
    .push_pc_i   (fetch_pc_q),
    .count_o     (count),
    .head_inst_o (inst),
    .head_pc_o   (inst_pc)
  );

  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = addr_q;
  assign inst_valid = (count != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory responder plus
// per-scenario tasks that check handshake timing, queue contents and redirects.
module tb_fetch_unit;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [15:0] inst;
  logic [15:0] inst_pc;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  bit mem_en  = 1'b1;
  int mem_lat = 1;
  bit inj_ack = 1'b0;
  int mem_cnt = 0;

  logic [15:0] got_pc[$];
  logic [15:0] got_inst[$];
  int          got_cyc[$];
  logic [15:0] ack_addr[$];
  int          ack_cyc[$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_data(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Memory: ack arrives mem_lat cycles after a request starts; a fresh request
  // starts right after each ack while imem_req stays high.
  initial begin
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        imem_ack   = inj_ack;
        imem_rdata = 16'hDEAD;
        mem_cnt    = 0;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
        mem_cnt  = imem_req ? 1 : 0;
      end else if (imem_req) begin
        if (mem_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = exp_data(imem_addr);
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Logs decode handshakes and memory acks once per cycle after inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && inst_valid && inst_ready) begin
        got_pc.push_back(inst_pc);
        got_inst.push_back(inst);
        got_cyc.push_back(cyc);
      end
      if (rst_n && imem_ack && imem_req) begin
        ack_addr.push_back(imem_addr);
        ack_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_pc.delete();
    got_inst.delete();
    got_cyc.delete();
    ack_addr.delete();
    ack_cyc.delete();
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b1;
    mem_en      = 1'b1;
    mem_lat     = 1;
    inj_ack     = 1'b0;
    step();
    step();
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_pc.size() >= n) break;
      step();
    end
    step();
    ok = (got_pc.size() >= n);
  endtask

  task automatic test_reset();
    #3;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    tests_run++; if (imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL rst_addr: got %h expected 0000", imem_addr); end
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
    tests_run++; if (inst !== 16'h0000) begin tests_failed++; $display("FAIL rst_inst: got %h expected 0000", inst); end
    tests_run++; if (inst_pc !== 16'h0000) begin tests_failed++; $display("FAIL rst_inst_pc: got %h expected 0000", inst_pc); end
    mem_en = 1'b0;
    step();
    rst_n = 1'b1;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_release_req: got %b expected 0", imem_req); end
    step();
    tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL first_req: got %b expected 1", imem_req); end
    tests_run++; if (imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL first_addr: got %h expected 0000", imem_addr); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_stream();
    bit ok;
    apply_reset();
    wait_got(4, 40, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL stream_timeout: got %0d insts expected 4", got_pc.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        tests_run++; if (got_pc[i] !== 16'(i)) begin tests_failed++; $display("FAIL stream_pc%0d: got %h expected %h", i, got_pc[i], 16'(i)); end
        tests_run++; if (got_inst[i] !== exp_data(16'(i))) begin tests_failed++; $display("FAIL stream_inst%0d: got %h expected %h", i, got_inst[i], exp_data(16'(i))); end
        tests_run++; if (ack_addr[i] !== 16'(i)) begin tests_failed++; $display("FAIL stream_addr%0d: got %h expected %h", i, ack_addr[i], 16'(i)); end
      end
      for (int i = 0; i < 3; i++) begin
        tests_run++; if (got_cyc[i+1] - got_cyc[i] !== 2) begin tests_failed++; $display("FAIL stream_rate%0d: got %0d cycles expected 2", i, got_cyc[i+1] - got_cyc[i]); end
      end
      tests_run++; if (got_cyc[0] !== ack_cyc[0] + 1) begin tests_failed++; $display("FAIL ack_to_valid: got cycle %0d expected %0d", got_cyc[0], ack_cyc[0] + 1); end
    end
    $display("[TB] test_stream done: %0d instructions", got_pc.size());
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    inst_ready = 1'b0;
    repeat (10) step();
    tests_run++; if (ack_addr.size() !== 2) begin tests_failed++; $display("FAIL bp_acks: got %0d expected 2", ack_addr.size()); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_req: got %b expected 0", imem_req); end
    tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid: got %b expected 1", inst_valid); end
    tests_run++; if (inst_pc !== 16'h0000) begin tests_failed++; $display("FAIL bp_head_pc: got %h expected 0000", inst_pc); end
    tests_run++; if (inst !== exp_data(16'h0000)) begin tests_failed++; $display("FAIL bp_head_inst: got %h expected %h", inst, exp_data(16'h0000)); end
    tests_run++; if (imem_addr !== 16'h0002) begin tests_failed++; $display("FAIL bp_next_addr: got %h expected 0002", imem_addr); end
    inst_ready = 1'b1;
    wait_got(4, 40, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL bp_timeout: got %0d insts expected 4", got_pc.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        tests_run++; if (got_pc[i] !== 16'(i)) begin tests_failed++; $display("FAIL bp_pc%0d: got %h expected %h", i, got_pc[i], 16'(i)); end
        tests_run++; if (ack_addr[i] !== 16'(i)) begin tests_failed++; $display("FAIL bp_addr%0d: got %h expected %h", i, ack_addr[i], 16'(i)); end
      end
    end
    $display("[TB] test_backpressure done: %0d instructions", got_pc.size());
  endtask

  task automatic test_redirect_wait();
    bit ok;
    bit found;
    bit seen5;
    int n0;
    apply_reset();
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (imem_req && imem_addr == 16'h0005 && !imem_ack) begin found = 1'b1; break; end
      step();
    end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL rdw_reach5: got no WAIT on 0005 expected one"); end
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    n0 = got_pc.size();
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rdw_flush: got valid %b expected 0", inst_valid); end
    tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL rdw_drop_req: got %b expected 1", imem_req); end
    wait_got(n0 + 1, 60, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL rdw_timeout: got %0d insts expected %0d", got_pc.size(), n0 + 1); end
    if (ok) begin
      tests_run++; if (got_pc[n0] !== 16'h0040) begin tests_failed++; $display("FAIL rdw_pc: got %h expected 0040", got_pc[n0]); end
      tests_run++; if (got_inst[n0] !== exp_data(16'h0040)) begin tests_failed++; $display("FAIL rdw_inst: got %h expected %h", got_inst[n0], exp_data(16'h0040)); end
    end
    seen5 = 1'b0;
    foreach (got_pc[i]) if (got_pc[i] == 16'h0005) seen5 = 1'b1;
    tests_run++; if (seen5 !== 1'b0) begin tests_failed++; $display("FAIL rdw_discard: got pc 0005 queued expected discarded"); end
    $display("[TB] test_redirect_wait done: next pc %h", (got_pc.size() > n0) ? got_pc[n0] : 16'hxxxx);
  endtask

  task automatic test_redirect_ack();
    bit ok;
    bit found;
    bit seen7;
    int n0;
    int r;
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (imem_ack && imem_addr == 16'h0007) begin found = 1'b1; break; end
      step();
    end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL rda_reach7: got no ack for 0007 expected one"); end
    r           = cyc;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    n0 = got_pc.size();
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rda_flush: got valid %b expected 0", inst_valid); end
    tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL rda_req: got %b expected 1", imem_req); end
    tests_run++; if (imem_addr !== 16'h0100) begin tests_failed++; $display("FAIL rda_addr: got %h expected 0100", imem_addr); end
    wait_got(n0 + 1, 20, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL rda_timeout: got %0d insts expected %0d", got_pc.size(), n0 + 1); end
    if (ok) begin
      tests_run++; if (got_pc[n0] !== 16'h0100) begin tests_failed++; $display("FAIL rda_pc: got %h expected 0100", got_pc[n0]); end
      tests_run++; if (got_inst[n0] !== exp_data(16'h0100)) begin tests_failed++; $display("FAIL rda_inst: got %h expected %h", got_inst[n0], exp_data(16'h0100)); end
      tests_run++; if (got_cyc[n0] !== r + 3) begin tests_failed++; $display("FAIL rda_no_drop: got cycle %0d expected %0d", got_cyc[n0], r + 3); end
    end
    seen7 = 1'b0;
    foreach (got_pc[i]) if (got_pc[i] == 16'h0007) seen7 = 1'b1;
    tests_run++; if (seen7 !== 1'b0) begin tests_failed++; $display("FAIL rda_discard: got pc 0007 queued expected discarded"); end
    $display("[TB] test_redirect_ack done: redirect cycle %0d", r);
  endtask

  task automatic test_wrap();
    bit ok;
    apply_reset();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    wait_got(2, 40, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL wrap_timeout: got %0d insts expected 2", got_pc.size()); end
    if (ok) begin
      tests_run++; if (got_pc[0] !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_pc0: got %h expected ffff", got_pc[0]); end
      tests_run++; if (got_pc[1] !== 16'h0000) begin tests_failed++; $display("FAIL wrap_pc1: got %h expected 0000", got_pc[1]); end
      tests_run++; if (got_inst[1] !== exp_data(16'h0000)) begin tests_failed++; $display("FAIL wrap_inst1: got %h expected %h", got_inst[1], exp_data(16'h0000)); end
      tests_run++; if (ack_addr[1] !== 16'h0000) begin tests_failed++; $display("FAIL wrap_addr1: got %h expected 0000", ack_addr[1]); end
    end
    $display("[TB] test_wrap done: %0d instructions", got_pc.size());
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ack_addr.size() >= 1) break;
      step();
    end
    mem_en = 1'b0;
    step();
    tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_req: got %b expected 1", imem_req); end
    tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_valid: got %b expected 1", inst_valid); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_req: got %b expected 0", imem_req); end
    tests_run++; if (imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL mid_rst_addr: got %h expected 0000", imem_addr); end
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid: got %b expected 0", inst_valid); end
    tests_run++; if (inst !== 16'h0000) begin tests_failed++; $display("FAIL mid_rst_inst: got %h expected 0000", inst); end
    tests_run++; if (inst_pc !== 16'h0000) begin tests_failed++; $display("FAIL mid_rst_inst_pc: got %h expected 0000", inst_pc); end
    inj_ack = 1'b1;
    step();
    step();
    rst_n   = 1'b1;
    inj_ack = 1'b0;
    step();
    tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL mid_post_req: got %b expected 1", imem_req); end
    tests_run++; if (imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL mid_post_addr: got %h expected 0000", imem_addr); end
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_late_ack: got valid %b expected 0", inst_valid); end
    clear_logs();
    mem_en     = 1'b1;
    inst_ready = 1'b1;
    wait_got(1, 20, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL mid_timeout: got %0d insts expected 1", got_pc.size()); end
    if (ok) begin
      tests_run++; if (got_pc[0] !== 16'h0000) begin tests_failed++; $display("FAIL mid_first_pc: got %h expected 0000", got_pc[0]); end
      tests_run++; if (got_inst[0] !== exp_data(16'h0000)) begin tests_failed++; $display("FAIL mid_first_inst: got %h expected %h", got_inst[0], exp_data(16'h0000)); end
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit core: owns the fetch program counter, issues word-addressed reads to instruction memory over a req/ack handshake, and buffers returned instructions with their addresses in a 2-entry queue for decode. It sits directly upstream of the next-PC `mux2`. It supplies `inst_pc`, from which PC+1 is formed downstream. It accepts the mux output back as `redirect_pc` whenever the branch path is selected.

## Interface
- `size`, 16, data and address width (instruction word = one address)
- `RESET_PC`, 0, first fetch address after reset
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `imem_req` output 1 — read request, level held until ack
- `imem_addr` output `size` — read address, stable while `imem_req`=1
- `imem_ack` input 1 — one-cycle completion; `imem_rdata` valid this cycle
- `imem_rdata` input `size` — instruction word
- `redirect` input 1 — one-cycle pulse: flush and restart at `redirect_pc`
- `redirect_pc` input `size` — new fetch address (next-PC mux output)
- `inst_valid` output 1 — queue head valid
- `inst_ready` input 1 — decode accepts head when `inst_valid`&`inst_ready`
- `inst` output `size` — head instruction
- `inst_pc` output `size` — address of head instruction

## Operation
- State machine: IDLE (no request outstanding), WAIT (request outstanding, data kept), DROP (request outstanding, data to be discarded).
- `imem_req` = (state != IDLE), registered. `imem_addr` = `fetch_pc` register.
- Queue: 2 entries of {inst, pc}; `count` 0..2; head drives `inst`/`inst_pc`; `inst_valid` = (`count` != 0).
- Transitions:
  - IDLE→WAIT when post-cycle `count` < 2.
  - WAIT + ack, no redirect: push {`imem_rdata`, `fetch_pc`}; `fetch_pc` <= `fetch_pc`+1; →WAIT if post-cycle `count` < 2, else IDLE.
  - WAIT + redirect, no ack: →DROP.
  - DROP + ack: discard data; →WAIT (queue is empty).
- Redirect, any state: queue cleared next cycle, `fetch_pc` <= `redirect_pc`.
  - IDLE: →WAIT.
  - DROP: stays DROP, latest target kept.
  - WAIT + ack in the same cycle: data discarded, →WAIT at `redirect_pc`, no DROP needed.
- Redirect has priority over push. A head handshake in the redirect cycle still counts as accepted.
- Pop and push in the same cycle leave `count` unchanged. Push is never attempted at `count`=2, because requests are gated.
- Arithmetic: `fetch_pc`+1 is modulo 2^`size`; 0xFFFF wraps to 0x0000 without a flag.
- Reset mid-transaction: state→IDLE, queue emptied, and any in-flight ack after reset is ignored. Memory must tolerate an abandoned request.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=0.
- First rising edge with `rst_n`=1: IDLE→WAIT; `imem_req`=1 from the next cycle.
- Ack in cycle t → `inst_valid`=1 in t+1 (queue was empty) and next request visible in t+1.
- Memory ack latency ≥1 cycle after `imem_req` rises. Peak throughput 1 instruction per 2 cycles.
- `redirect` in cycle t → `inst_valid`=0 in t+1. The first new instruction arrives no earlier than the ack for `redirect_pc`.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `risc_pkg`:
  - fetch state enum (IDLE/WAIT/DROP)
  - `RESET_PC` default
  - word-width constant 16, consistent with `mux2` `size`
- Sub-module `fetch_queue`: 2-entry {inst, pc} FIFO with push, pop, flush, count, and head outputs. The FSM and PC register live in the top.

## Test plan
- Reset, ack latency 1, `inst_ready`=1 → addresses 0,1,2,3 requested; `inst_pc` 0,1,2,3 with matching data, one instruction per 2 cycles.
- `inst_ready`=0 → queue fills to 2 (pc 0,1); `imem_req` drops after the second ack. Raising ready resumes the fetch of addr 2 with no loss or duplication.
- Redirect to 0x0040 while WAIT on addr 5 with 3-cycle ack → addr 5 data discarded; next `inst_pc`=0x0040; queue empty the cycle after redirect.
- Redirect to 0x0100 in the same cycle as the ack for addr 7 → addr 7 not queued; next request addr 0x0100 with no DROP phase.
- `redirect_pc`=0xFFFF → fetches 0xFFFF then 0x0000.
- `rst_n` low while WAIT, late ack → ignored; after release, first request is `RESET_PC`; all outputs at reset values.
